// File: rtl/signed_mac_accumulator_pkg.sv
// rtl/signed_mac_accumulator_pkg.sv - shared types, constants and helpers for the signed MAC accumulator
//
// Purpose : FSM state enumeration, product width constant and the signed
//           saturation limit helper used by mac_sat_adder.
// Ports   : none (package).
// Config  : SIGNED_MAC_SAT_EN selects clamping in mac_sat_adder; the
//           package content is identical in both builds.

package signed_mac_accumulator_pkg;

  // Frame FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } mac_state_e;

  // Width of the signed 3x3 multiplier product feeding the accumulator.
  localparam int PROD_W = 6;

  // Bit pattern of the signed limit for a width-bit accumulator, returned
  // right-aligned in 32 bits; the caller truncates to its own width.
  // 1 << (width-1) truncated to width bits is exactly the most negative
  // value, and one less than it is the most positive value.
  function automatic logic [31:0] sat_limit(input int unsigned width,
                                            input logic        negative);
    logic [31:0] msb;
    msb = 32'h1 << (width - 1);
    return negative ? msb : (msb - 32'h1);
  endfunction

endpackage

// File: rtl/mac_sat_adder.sv
// rtl/mac_sat_adder.sv - sign-extending accumulate adder with overflow detect and optional clamp
//
// Purpose : Adds a sign-extended product to the running accumulator (or to
//           zero on the first beat of a frame), flags when the true sum
//           leaves the ACC_W signed range and either wraps or clamps.
// Config  : SIGNED_MAC_SAT_EN defined   -> out-of-range results clamp to
//                                          the signed min/max.
//           SIGNED_MAC_SAT_EN undefined -> results wrap modulo 2^ACC_W.
// Ports   :
//   load_i     in   1        treat the accumulator as zero (frame start)
//   acc_i      in   ACC_W    current accumulator value (signed)
//   product_i  in   PROD_W   signed product to add
//   sum_o      out  ACC_W    next accumulator value
//   ovf_o      out  1        true sum was outside the ACC_W signed range

module mac_sat_adder
  import signed_mac_accumulator_pkg::*;
#(
  parameter int ACC_W = 10
) (
  input  logic              load_i,
  input  logic [ACC_W-1:0]  acc_i,
  input  logic [PROD_W-1:0] product_i,
  output logic [ACC_W-1:0]  sum_o,
  output logic              ovf_o
);

  // One guard bit above ACC_W holds the true sign of the sum of two
  // ACC_W-bit signed operands, so no information is lost here.
  logic [ACC_W:0] acc_ext;
  logic [ACC_W:0] prod_ext;
  logic [ACC_W:0] wide;

  assign acc_ext  = load_i ? '0 : {acc_i[ACC_W-1], acc_i};
  assign prod_ext = {{(ACC_W + 1 - PROD_W){product_i[PROD_W-1]}}, product_i};
  assign wide     = acc_ext + prod_ext;

  // The result fits only if the guard bit agrees with the ACC_W sign bit.
  assign ovf_o = wide[ACC_W] ^ wide[ACC_W-1];

`ifdef SIGNED_MAC_SAT_EN
  logic [ACC_W-1:0] lim_pos;
  logic [ACC_W-1:0] lim_neg;

  assign lim_pos = ACC_W'(sat_limit(ACC_W, 1'b0));
  assign lim_neg = ACC_W'(sat_limit(ACC_W, 1'b1));

  // The guard bit gives the direction of the excursion.
  assign sum_o = !ovf_o      ? wide[ACC_W-1:0] :
                 wide[ACC_W] ? lim_neg         : lim_pos;
`else
  assign sum_o = wide[ACC_W-1:0];
`endif

endmodule

// File: rtl/signed_mac_accumulator.sv
// rtl/signed_mac_accumulator.sv - framed signed multiply-accumulate with valid/ready handshakes
//
// Purpose : Sums COUNT signed 6-bit products per frame, presents the frame
//           total with a sticky overflow flag and holds it until taken.
// Config  : SIGNED_MAC_SAT_EN (see mac_sat_adder) selects clamp vs wrap on
//           an out-of-range add; overflow is flagged in both builds.
// Params  : COUNT  products per frame (2..16)
//           ACC_W  accumulator / result width (7..32)
// Ports   :
//   clk        in   1       rising-edge clock
//   rst_n      in   1       asynchronous active-low reset
//   clear      in   1       synchronous frame abort, wins over everything
//   in_valid   in   1       product is valid
//   product    in   6       signed product
//   in_ready   out  1       a product beat can be accepted
//   out_valid  out  1       sum holds a completed frame total
//   out_ready  in   1       consumer takes sum
//   sum        out  ACC_W   signed frame total
//   overflow   out  1       frame overflow flag, meaningful with out_valid

module signed_mac_accumulator
  import signed_mac_accumulator_pkg::*;
#(
  parameter int COUNT = 4,
  parameter int ACC_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [PROD_W-1:0] product,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  sum,
  output logic              overflow
);

  localparam int CNT_W = $clog2(COUNT + 1);

  mac_state_e       state_q;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] sum_q;
  logic [CNT_W-1:0] cnt_q;
  logic             out_valid_q;
  logic             ovf_q;

  logic [ACC_W-1:0] acc_d;
  logic             add_ovf;
  logic             beat;
  logic             last_beat;
  logic             load;

  // State resets to IDLE, so in_ready reads 1 while reset is held.
  assign in_ready  = (state_q != DONE);
  assign beat      = in_valid & in_ready;
  assign last_beat = (cnt_q == CNT_W'(COUNT - 1));
  // First beat of a frame starts from zero rather than whatever acc holds.
  assign load      = (state_q == IDLE);

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign overflow  = ovf_q;

  mac_sat_adder #(
    .ACC_W (ACC_W)
  ) u_adder (
    .load_i    (load),
    .acc_i     (acc_q),
    .product_i (product),
    .sum_o     (acc_d),
    .ovf_o     (add_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      sum_q       <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (clear) begin
      // Abort drops any beat or handshake on this cycle and any pending sum.
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (beat) begin
            acc_q   <= acc_d;
            cnt_q   <= CNT_W'(1);
            ovf_q   <= add_ovf;
            state_q <= ACC;
          end
        end

        ACC: begin
          if (beat) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + CNT_W'(1);
            ovf_q <= ovf_q | add_ovf;
            if (last_beat) begin
              state_q     <= DONE;
              sum_q       <= acc_d;
              out_valid_q <= 1'b1;
            end
          end
        end

        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
          end
        end

        default: begin
          state_q     <= IDLE;
          acc_q       <= '0;
          cnt_q       <= '0;
          out_valid_q <= 1'b0;
          ovf_q       <= 1'b0;
        end
      endcase
    end
  end

endmodule
